// File: rtl/load_input_buffer.sv
// load_input_buffer
//   Packs IN_W-bit words, LSB-first, into IMG_BITS-bit image banks.
//   A completed bank is presented to the network core through a registered,
//   RD_W-bit random read port. With DOUBLE_BUF=1, two ping-pong banks let
//   the next image load while the core is still reading the current one.
//
// Ports
//   clk        system clock, all state changes on posedge
//   rst        synchronous active-high reset
//   trigger    one-cycle strobe, data is valid in that cycle
//   data       IN_W-bit input word
//   addr       read address into the ready bank, in units of RD_W bits
//   q          registered read data, one cycle after addr
//   ready      a full bank is presented on the read port
//   release_i  core is finished with the read bank (takes effect only while ready=1)
//   loading    the write bank is partially filled
//   drop       one-cycle pulse: a trigger found no free bank and was discarded
//   wr_cnt     words stored so far in the current write bank
//
// Handshake
//   trigger/data is a push with no backpressure: a word offered while the
//   write bank is FULL is lost and reported on drop the next cycle.
//   release_i is a request qualified by ready; when ready=0 it is ignored.
module load_input_buffer #(
  parameter int IN_W       = 8,
  parameter int IMG_BITS   = 784,
  parameter int RD_W       = 1,
  parameter int DOUBLE_BUF = 1,
  localparam int WORDS     = IMG_BITS / IN_W,
  localparam int RDEPTH    = IMG_BITS / RD_W,
  localparam int RA_W      = (RDEPTH > 1) ? $clog2(RDEPTH) : 1,
  localparam int WC_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trigger,
  input  logic [IN_W-1:0] data,
  input  logic [RA_W-1:0] addr,
  output logic [RD_W-1:0] q,
  output logic            ready,
  input  logic            release_i,
  output logic            loading,
  output logic            drop,
  output logic [WC_W-1:0] wr_cnt
);

  // Bit indices are one bit wider than an image index so that an
  // out-of-range read address cannot wrap back into the image.
  localparam int IX_W = $clog2(IMG_BITS) + 1;
  localparam logic [WC_W-1:0] LAST_CNT = WC_W'(WORDS - 1);

  // Two banks are always declared; with DOUBLE_BUF=0 both selects stay at
  // bank 0 and bank 1 is never written.
  logic [IMG_BITS-1:0] bank_q [2];
  logic [IMG_BITS-1:0] bank_d [2];
  logic [1:0]          full_q, full_d;      // per-bank FULL(1)/EMPTY(0)
  logic                wr_sel_q, wr_sel_d;
  logic                rd_sel_q, rd_sel_d;
  logic [WC_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic                ready_q, ready_d;
  logic                drop_q, drop_d;
  logic [RD_W-1:0]     q_q, q_d;

  logic [IX_W-1:0]     wr_idx;
  logic [IX_W-1:0]     rd_idx;
  logic                wr_ok;
  logic                rel_ok;

  always_comb begin
    bank_d   = bank_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_cnt_d = wr_cnt_q;
    drop_d   = 1'b0;
    q_d      = '0;

    wr_idx = IX_W'(wr_cnt_q) * IX_W'(IN_W);
    rd_idx = IX_W'(addr) * IX_W'(RD_W);

    // The FULL test uses the pre-release state, so a word aimed at a bank
    // that is being released this same cycle is dropped rather than bypassed.
    wr_ok  = trigger && !full_q[wr_sel_q];
    rel_ok = release_i && ready_q;

    if (rel_ok) begin
      full_d[rd_sel_q] = 1'b0;
      if (DOUBLE_BUF != 0) rd_sel_d = ~rd_sel_q;
    end

    // A release and a last-word write never target the same bank: the
    // released bank is FULL and the written bank must be EMPTY.
    if (wr_ok) begin
      bank_d[wr_sel_q][wr_idx +: IN_W] = data;
      if (wr_cnt_q == LAST_CNT) begin
        wr_cnt_d         = '0;
        full_d[wr_sel_q] = 1'b1;
        if (DOUBLE_BUF != 0) wr_sel_d = ~wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    drop_d = trigger && full_q[wr_sel_q];

    // ready tracks the bank that will be on the read port after this edge,
    // so a release with the other bank already FULL leaves no gap.
    ready_d = full_d[rd_sel_d];

    if (IX_W'(addr) < IX_W'(RDEPTH)) begin
      q_d = bank_q[rd_sel_q][rd_idx +: RD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      ready_q  <= 1'b0;
      drop_q   <= 1'b0;
      q_q      <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      ready_q  <= ready_d;
      drop_q   <= drop_d;
      q_q      <= q_d;
    end
  end

  // Image storage is deliberately not reset; a bank is only ever read once
  // it has been completely rewritten.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_q <= bank_d;
    end
  end

  assign q       = q_q;
  assign ready   = ready_q;
  assign drop    = drop_q;
  assign wr_cnt  = wr_cnt_q;
  assign loading = (wr_cnt_q != '0);

endmodule

// File: tb/tb_load_input_buffer.sv
// Bench for load_input_buffer. Three instances share clock and reset:
//   k=0 defaults (8-bit words, 1-bit reads, double bank)
//   k=1 single bank
//   k=2 16-bit words, 8-bit reads
// The reference model keeps each instance as a queue of completed images
// plus one partial image being assembled.
module tb_load_input_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        trg [3];
  logic        rel [3];
  logic [15:0] dat [3];
  logic [9:0]  adr [3];

  logic        a_q, b_q;
  logic [7:0]  c_q;
  logic [6:0]  a_cnt, b_cnt;
  logic [5:0]  c_cnt;
  logic        o_ready [3];
  logic        o_drop [3];
  logic        o_loading [3];
  logic [7:0]  o_q [3];
  logic [6:0]  o_cnt [3];

  load_input_buffer u_dbl (
    .clk(clk), .rst(rst), .trigger(trg[0]), .data(dat[0][7:0]), .addr(adr[0]),
    .q(a_q), .ready(o_ready[0]), .release_i(rel[0]), .loading(o_loading[0]),
    .drop(o_drop[0]), .wr_cnt(a_cnt));

  load_input_buffer #(.DOUBLE_BUF(0)) u_sgl (
    .clk(clk), .rst(rst), .trigger(trg[1]), .data(dat[1][7:0]), .addr(adr[1]),
    .q(b_q), .ready(o_ready[1]), .release_i(rel[1]), .loading(o_loading[1]),
    .drop(o_drop[1]), .wr_cnt(b_cnt));

  load_input_buffer #(.IN_W(16), .RD_W(8)) u_wide (
    .clk(clk), .rst(rst), .trigger(trg[2]), .data(dat[2]), .addr(adr[2][6:0]),
    .q(c_q), .ready(o_ready[2]), .release_i(rel[2]), .loading(o_loading[2]),
    .drop(o_drop[2]), .wr_cnt(c_cnt));

  assign o_q[0]   = {7'b0, a_q};
  assign o_q[1]   = {7'b0, b_q};
  assign o_q[2]   = c_q;
  assign o_cnt[0] = a_cnt;
  assign o_cnt[1] = b_cnt;
  assign o_cnt[2] = {1'b0, c_cnt};

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int CAP  [3] = '{2, 1, 2};
  int NWRD [3] = '{98, 98, 49};
  int WIN  [3] = '{8, 8, 16};
  int RW   [3] = '{1, 1, 8};
  int RDEP [3] = '{784, 784, 98};

  logic [783:0] m_img [3][2];
  logic [783:0] m_part [3];
  int           m_size [3];
  int           m_cnt [3];

  logic       e_ready [3];
  logic       e_drop [3];
  logic       e_qv [3];
  logic [7:0] e_q [3];
  int         e_cnt [3];

  logic [7:0] exp_q[$];

  // Advance one clock: predict from the pre-edge state, then apply the edge.
  task automatic tick();
    logic acc [3];
    for (int k = 0; k < 3; k++) begin
      acc[k]    = trg[k] && (m_size[k] < CAP[k]);
      e_drop[k] = !rst && trg[k] && (m_size[k] == CAP[k]);
      e_qv[k]   = rst || (int'(adr[k]) >= RDEP[k]) || (m_size[k] > 0);
      e_q[k]    = 8'h00;
      if (!rst && int'(adr[k]) < RDEP[k] && m_size[k] > 0)
        for (int b = 0; b < RW[k]; b++)
          e_q[k][b] = m_img[k][0][int'(adr[k]) * RW[k] + b];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_size[k] = 0;
        m_cnt[k]  = 0;
        m_part[k] = '0;
      end else begin
        if (rel[k] && m_size[k] > 0) begin
          m_img[k][0] = m_img[k][1];
          m_size[k]--;
        end
        if (acc[k]) begin
          for (int b = 0; b < WIN[k]; b++)
            m_part[k][m_cnt[k] * WIN[k] + b] = dat[k][b];
          m_cnt[k]++;
          if (m_cnt[k] == NWRD[k]) begin
            m_img[k][m_size[k]] = m_part[k];
            m_size[k]++;
            m_cnt[k] = 0;
          end
        end
      end
      e_ready[k] = (m_size[k] > 0);
      e_cnt[k]   = m_cnt[k];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    for (int k = 0; k < 3; k++) begin
      trg[k] = 1'b0;
      rel[k] = 1'b0;
      dat[k] = '0;
      adr[k] = '0;
    end
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_word(input int k, input logic [15:0] d);
    trg[k] = 1'b1;
    dat[k] = d;
    tick();
    trg[k] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      total += 5;
      if (o_ready[k] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got %b exp 0", k, o_ready[k]); end
      if (o_q[k] !== 8'h00) begin bad++; $display("FAIL reset_q[%0d] got %h exp 00", k, o_q[k]); end
      if (o_drop[k] !== 1'b0) begin bad++; $display("FAIL reset_drop[%0d] got %b exp 0", k, o_drop[k]); end
      if (o_loading[k] !== 1'b0) begin bad++; $display("FAIL reset_loading[%0d] got %b exp 0", k, o_loading[k]); end
      if (o_cnt[k] !== 7'd0) begin bad++; $display("FAIL reset_wr_cnt[%0d] got %0d exp 0", k, o_cnt[k]); end
    end
  endtask

  task automatic test_fill_ones();
    do_reset();
    for (int i = 1; i <= 98; i++) begin
      push_word(0, 16'h00FF);
      total++;
      if (o_ready[0] !== (i == 98)) begin
        bad++; $display("FAIL fill_ready word %0d got %b exp %b", i, o_ready[0], (i == 98));
      end
    end
    for (int a = 0; a < 784; a++) begin
      adr[0] = 10'(a);
      tick();
      total++;
      if (o_q[0] !== 8'h01) begin bad++; $display("FAIL fill_q addr %0d got %h exp 01", a, o_q[0]); end
    end
  endtask

  task automatic test_pattern();
    logic [7:0] byt;
    do_reset();
    for (int k = 0; k < 98; k++) begin
      push_word(0, {8'h00, 8'hA5 ^ 8'(k)});
      for (int g = 0; g < 50; g++) begin
        total += 2;
        if (o_loading[0] !== (k != 97)) begin
          bad++; $display("FAIL pat_loading word %0d got %b exp %b", k, o_loading[0], (k != 97));
        end
        if (o_cnt[0] !== 7'((k + 1) % 98)) begin
          bad++; $display("FAIL pat_wr_cnt word %0d got %0d exp %0d", k, o_cnt[0], (k + 1) % 98);
        end
        if (g < 49) tick();
      end
    end
    for (int a = 0; a < 784; a++) begin
      adr[0] = 10'(a);
      tick();
      byt = 8'hA5 ^ 8'(a / 8);
      total++;
      if (o_q[0] !== {7'b0, byt[a % 8]}) begin
        bad++; $display("FAIL pat_q addr %0d got %h exp %h", a, o_q[0], byt[a % 8]);
      end
    end
  endtask

  task automatic test_double_buffer();
    int a;
    do_reset();
    for (int i = 0; i < 98; i++) push_word(0, 16'h000F);
    for (int i = 0; i < 98; i++) begin
      a = $urandom_range(0, 783);
      adr[0] = 10'(a);
      push_word(0, 16'h00F0);
      total++;
      if (o_q[0] !== {7'b0, ((a % 8) < 4)}) begin
        bad++; $display("FAIL dbl_read_a addr %0d got %h exp %0d", a, o_q[0], ((a % 8) < 4));
      end
    end
    adr[0] = 10'd0;
    rel[0] = 1'b1;
    tick();
    rel[0] = 1'b0;
    total += 2;
    if (o_ready[0] !== 1'b1) begin bad++; $display("FAIL dbl_ready_after_rel1 got %b exp 1", o_ready[0]); end
    if (o_q[0] !== 8'h01) begin bad++; $display("FAIL dbl_q_last_a got %h exp 01", o_q[0]); end
    tick();
    total += 2;
    if (o_ready[0] !== 1'b1) begin bad++; $display("FAIL dbl_ready_gap got %b exp 1", o_ready[0]); end
    if (o_q[0] !== 8'h00) begin bad++; $display("FAIL dbl_q_b_addr0 got %h exp 00", o_q[0]); end
    rel[0] = 1'b1;
    tick();
    rel[0] = 1'b0;
    total++;
    if (o_ready[0] !== 1'b0) begin bad++; $display("FAIL dbl_ready_after_rel2 got %b exp 0", o_ready[0]); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 196; i++) begin
      trg[1] = (i < 98);
      dat[1] = 16'h003C;
      push_word(0, (i < 98) ? 16'h000F : 16'h00F0);
    end
    trg[1] = 1'b1;
    push_word(0, 16'h00AA);
    for (int k = 0; k < 2; k++) begin
      total += 2;
      if (o_drop[k] !== 1'b1) begin bad++; $display("FAIL ovf_drop[%0d] got %b exp 1", k, o_drop[k]); end
      if (o_cnt[k] !== 7'd0) begin bad++; $display("FAIL ovf_wr_cnt[%0d] got %0d exp 0", k, o_cnt[k]); end
    end
    trg[1] = 1'b0;
    for (int a = 0; a < 8; a++) begin
      adr[0] = 10'(a);
      adr[1] = 10'(a);
      tick();
      total += 3;
      if (o_q[0] !== {7'b0, (a < 4)}) begin bad++; $display("FAIL ovf_a_intact addr %0d got %h", a, o_q[0]); end
      if (o_q[1] !== {7'b0, (a >= 2 && a <= 5)}) begin bad++; $display("FAIL ovf_sgl_intact addr %0d got %h", a, o_q[1]); end
      if (a == 0) begin
        if (o_drop[0] !== 1'b0 || o_drop[1] !== 1'b0) begin
          bad++; $display("FAIL ovf_drop_width got %b%b exp 00", o_drop[0], o_drop[1]);
        end
      end else if (o_ready[1] !== 1'b1) begin
        bad++; $display("FAIL ovf_sgl_ready got %b exp 1", o_ready[1]);
      end
    end
    // a word aimed at a bank being released in the same cycle is lost
    rel[1] = 1'b1;
    push_word(1, 16'h0055);
    rel[1] = 1'b0;
    total += 3;
    if (o_drop[1] !== 1'b1) begin bad++; $display("FAIL relw_drop got %b exp 1", o_drop[1]); end
    if (o_cnt[1] !== 7'd0) begin bad++; $display("FAIL relw_wr_cnt got %0d exp 0", o_cnt[1]); end
    if (o_ready[1] !== 1'b0) begin bad++; $display("FAIL relw_ready got %b exp 0", o_ready[1]); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] byt;
    do_reset();
    for (int i = 0; i < 40; i++) push_word(0, 16'($urandom_range(0, 255)));
    total += 2;
    if (o_cnt[0] !== 7'd40) begin bad++; $display("FAIL mid_wr_cnt40 got %0d exp 40", o_cnt[0]); end
    if (o_loading[0] !== 1'b1) begin bad++; $display("FAIL mid_loading got %b exp 1", o_loading[0]); end
    do_reset();
    total += 3;
    if (o_cnt[0] !== 7'd0) begin bad++; $display("FAIL mid_rst_wr_cnt got %0d exp 0", o_cnt[0]); end
    if (o_ready[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got %b exp 0", o_ready[0]); end
    if (o_loading[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_loading got %b exp 0", o_loading[0]); end
    exp_q.delete();
    for (int i = 1; i <= 98; i++) begin
      byt = 8'($urandom_range(0, 255));
      exp_q.push_back(byt);
      push_word(0, {8'h00, byt});
      total++;
      if (o_ready[0] !== (i == 98)) begin
        bad++; $display("FAIL mid_reload_ready word %0d got %b exp %b", i, o_ready[0], (i == 98));
      end
    end
    for (int a = 0; a < 784; a++) begin
      adr[0] = 10'(a);
      tick();
      byt = exp_q[a / 8];
      total++;
      if (o_q[0] !== {7'b0, byt[a % 8]}) begin
        bad++; $display("FAIL mid_q addr %0d got %h exp %h", a, o_q[0], byt[a % 8]);
      end
    end
  endtask

  task automatic test_wide();
    logic [15:0] w;
    logic [7:0]  want;
    do_reset();
    exp_q.delete();
    for (int i = 1; i <= 49; i++) begin
      w = 16'($urandom_range(0, 65535));
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
      push_word(2, w);
      total++;
      if (o_ready[2] !== (i == 49)) begin
        bad++; $display("FAIL wide_ready word %0d got %b exp %b", i, o_ready[2], (i == 49));
      end
    end
    for (int a = 0; a < 128; a++) begin
      adr[2] = 10'(a);
      tick();
      want = (a < 98) ? exp_q[a] : 8'h00;
      total++;
      if (o_q[2] !== want) begin bad++; $display("FAIL wide_q addr %0d got %h exp %h", a, o_q[2], want); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        trg[k] = ($urandom_range(0, 3) == 0);
        rel[k] = ($urandom_range(0, 99) < 2);
        dat[k] = 16'($urandom_range(0, 65535));
        adr[k] = (k == 2) ? 10'($urandom_range(0, 127)) : 10'($urandom_range(0, 1023));
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        total += 4;
        if (o_ready[k] !== e_ready[k]) begin bad++; $display("FAIL rnd_ready[%0d] cyc %0d got %b exp %b", k, c, o_ready[k], e_ready[k]); end
        if (o_drop[k] !== e_drop[k]) begin bad++; $display("FAIL rnd_drop[%0d] cyc %0d got %b exp %b", k, c, o_drop[k], e_drop[k]); end
        if (o_cnt[k] !== 7'(e_cnt[k])) begin bad++; $display("FAIL rnd_wr_cnt[%0d] cyc %0d got %0d exp %0d", k, c, o_cnt[k], e_cnt[k]); end
        if (o_loading[k] !== (e_cnt[k] != 0)) begin bad++; $display("FAIL rnd_loading[%0d] cyc %0d got %b", k, c, o_loading[k]); end
        if (e_qv[k]) begin
          total++;
          if (o_q[k] !== e_q[k]) begin bad++; $display("FAIL rnd_q[%0d] cyc %0d got %h exp %h", k, c, o_q[k], e_q[k]); end
        end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_fill_ones();
    test_pattern();
    test_double_buffer();
    test_overflow();
    test_mid_reset();
    test_wide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
